blk_sched: RTL and testbench
============================

Name: blk_sched

Overview:
- Block scheduler for the sha256 engine's block-creation path.
- Selects one of N_THREADS requesting threads round-robin and issues a single-cycle blk_start with thread_num and new_comp to the block-creation unit.
- Holds off further starts until that unit signals blk_end.
- Reports computation completion per thread, counts blocks and flags protocol errors and timeouts.

Parameters:
- N_THREADS, 6: number of threads sharing the block-creation datapath.
- N_THREADS_MSB, `MSB(N_THREADS-1): MSB of the thread number.
- BLK_TIMEOUT, 127: maximum cycles from blk_start to blk_end before err. Range 8..255.

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-high reset.
- thread_req  in  N_THREADS  bit i: thread i has data for a new block.
- thread_new_comp  in  N_THREADS  bit i: thread i's next block starts a new computation.
- core_rdy  in  1  downstream sha256 core can accept another block.
- blk_end  in  1  one-cycle pulse from block creation: current block finished.
- end_comp  in  1  valid with blk_end: the finished block ended the computation.
- blk_start  out  1  one-cycle start pulse to block creation.
- new_comp  out  1  valid with blk_start.
- thread_num  out  N_THREADS_MSB+1  granted thread. Stable from blk_start until the next grant.
- thread_ack  out  N_THREADS  one-hot pulse, coincident with blk_start.
- thread_done  out  N_THREADS  one-hot pulse: computation of that thread finished.
- busy  out  1  a block is in flight (states START, WAIT).
- blk_count  out  16  blocks completed since reset. Wraps 0xFFFF to 0.
- err  out  1  sticky error.

Behaviour:
- Reset (async, RESET=1):
  - state=IDLE.
  - blk_start=0, new_comp=0, thread_num=0, thread_ack=0, thread_done=0.
  - busy=0, blk_count=0, err=0, timeout counter=0.
  - last_thread=N_THREADS-1, so thread 0 has priority first.
  - Reset asserted mid-block abandons the block; no thread_done is issued.
- States: IDLE, START, WAIT, ERR.
- IDLE:
  - If core_rdy=1 and thread_req!=0, pick the first set bit searching last_thread+1, last_thread+2, ... with wrap N_THREADS-1 -> 0.
  - Register thread_num and new_comp=thread_new_comp[pick], set blk_start=1 and thread_ack[pick]=1, then go to START.
  - Otherwise remain in IDLE with all pulses at 0.
  - Latency: request sampled at edge t gives blk_start high in cycle t+1.
- START:
  - blk_start, thread_ack and new_comp clear after exactly one cycle.
  - Timeout counter is cleared; go to WAIT.
- WAIT:
  - thread_req and core_rdy are ignored.
  - Counter increments each cycle.
  - On blk_end=1:
    - blk_count+1 and last_thread<=thread_num.
    - If end_comp=1, thread_done[thread_num]=1 for one cycle.
    - Go to IDLE.
  - The earliest next blk_start is 2 cycles after blk_end.
  - If the counter reaches BLK_TIMEOUT with no blk_end: err=1, go to ERR.
- ERR: terminal; no starts issued; exit only via RESET.
- Protocol errors:
  - blk_end while in IDLE or START sets err=1 and goes to ERR.
  - end_comp without blk_end is ignored.
- Simultaneous events:
  - blk_end together with timeout expiry counts as a normal completion.
  - A requester deasserting after grant has no effect.
  - Only one grant is in flight at any time.
- Arithmetic:
  - Timeout counter is 8 bits.
  - blk_count is 16 bits and wraps.
  - Round-robin index is modulo N_THREADS, also for non-power-of-2 counts.

Test Plan:
- Reset, thread_req=6'b000001, core_rdy=1, blk_end 10 cycles after start with end_comp=1 -> blk_start in cycle 1 after release, thread_num=0, thread_done=6'b000001, blk_count=1.
- thread_req=6'b111111 held, blk_end returned 5 cycles after each start -> grants 0,1,2,3,4,5,0; consecutive blk_start pulses 7 cycles apart; blk_count=7.
- thread_req=6'b100100 with last_thread=5 -> grant 2, then 5, then 2. Wrap from 5 to 0 skips idle threads.
- core_rdy=0 with thread_req=6'b001000 for 20 cycles, then core_rdy=1 -> no blk_start while low; blk_start 1 cycle after rise; new_comp equals thread_new_comp[3].
- blk_start with no blk_end, BLK_TIMEOUT=127 -> err=1 at cycle 128 after blk_start, no further starts. RESET pulse clears err and restarts from thread 0.
- blk_end injected in IDLE -> err=1. RESET asserted during WAIT -> all outputs 0 immediately, no thread_done.

Source files
------------

// File: rtl/blk_sched_if.sv
// rtl/blk_sched_if.sv - request/grant and block-creation handshake bundle for blk_sched
interface blk_sched_if #(
    parameter int N_THREADS = 6
);
    localparam int TW = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;

    logic [N_THREADS-1:0] thread_req;
    logic [N_THREADS-1:0] thread_new_comp;
    logic                 core_rdy;
    logic                 blk_end;
    logic                 end_comp;
    logic                 blk_start;
    logic                 new_comp;
    logic [TW-1:0]        thread_num;
    logic [N_THREADS-1:0] thread_ack;
    logic [N_THREADS-1:0] thread_done;
    logic                 busy;
    logic [15:0]          blk_count;
    logic                 err;

    modport master (
        input  thread_req, thread_new_comp, core_rdy, blk_end, end_comp,
        output blk_start, new_comp, thread_num, thread_ack, thread_done,
               busy, blk_count, err
    );

    modport slave (
        output thread_req, thread_new_comp, core_rdy, blk_end, end_comp,
        input  blk_start, new_comp, thread_num, thread_ack, thread_done,
               busy, blk_count, err
    );
endinterface

// File: rtl/blk_sched.sv
// rtl/blk_sched.sv - round-robin block scheduler for the sha256 block-creation path
module blk_sched #(
    parameter int N_THREADS   = 6,
    parameter int BLK_TIMEOUT = 127
) (
    input  logic        CLK,
    input  logic        RESET,
    blk_sched_if.master bus
);
    localparam int TW = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_ERR} state_t;

    state_t               state_q, state_d;
    logic                 blk_start_q, blk_start_d;
    logic                 new_comp_q, new_comp_d;
    logic [TW-1:0]        thread_num_q, thread_num_d;
    logic [N_THREADS-1:0] thread_ack_q, thread_ack_d;
    logic [N_THREADS-1:0] thread_done_q, thread_done_d;
    logic                 busy_q, busy_d;
    logic [15:0]          blk_count_q, blk_count_d;
    logic                 err_q, err_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [TW-1:0]        last_q, last_d;

    logic                 pick_found;
    logic [TW-1:0]        pick_idx;
    logic [TW:0]          scan_sum;
    logic [TW-1:0]        scan_idx;

    // Scan last+1, last+2, ... modulo N_THREADS; the first requester wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int i = 1; i <= N_THREADS; i++) begin
            scan_sum = {1'b0, last_q} + (TW+1)'(i);
            if (scan_sum >= (TW+1)'(N_THREADS)) begin
                scan_sum = scan_sum - (TW+1)'(N_THREADS);
            end
            scan_idx = scan_sum[TW-1:0];
            if (!pick_found && bus.thread_req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        blk_start_d   = 1'b0;
        new_comp_d    = 1'b0;
        thread_ack_d  = '0;
        thread_done_d = '0;
        thread_num_d  = thread_num_q;
        busy_d        = busy_q;
        blk_count_d   = blk_count_q;
        err_d         = err_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        case (state_q)
            S_IDLE: begin
                if (bus.blk_end) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else if (bus.core_rdy && pick_found) begin
                    thread_num_d           = pick_idx;
                    new_comp_d             = bus.thread_new_comp[pick_idx];
                    blk_start_d            = 1'b1;
                    thread_ack_d[pick_idx] = 1'b1;
                    busy_d                 = 1'b1;
                    state_d                = S_START;
                end
            end
            S_START: begin
                if (bus.blk_end) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_ERR;
                end else begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A blk_end coinciding with expiry still counts as a completion.
                if (bus.blk_end) begin
                    blk_count_d = blk_count_q + 16'd1;
                    last_d      = thread_num_q;
                    if (bus.end_comp) begin
                        thread_done_d[thread_num_q] = 1'b1;
                    end
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == 8'(BLK_TIMEOUT)) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_ERR;
                    end
                end
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            blk_start_q   <= 1'b0;
            new_comp_q    <= 1'b0;
            thread_num_q  <= '0;
            thread_ack_q  <= '0;
            thread_done_q <= '0;
            busy_q        <= 1'b0;
            blk_count_q   <= '0;
            err_q         <= 1'b0;
            cnt_q         <= '0;
            last_q        <= TW'(N_THREADS - 1);
        end else begin
            state_q       <= state_d;
            blk_start_q   <= blk_start_d;
            new_comp_q    <= new_comp_d;
            thread_num_q  <= thread_num_d;
            thread_ack_q  <= thread_ack_d;
            thread_done_q <= thread_done_d;
            busy_q        <= busy_d;
            blk_count_q   <= blk_count_d;
            err_q         <= err_d;
            cnt_q         <= cnt_d;
            last_q        <= last_d;
        end
    end

    assign bus.blk_start   = blk_start_q;
    assign bus.new_comp    = new_comp_q;
    assign bus.thread_num  = thread_num_q;
    assign bus.thread_ack  = thread_ack_q;
    assign bus.thread_done = thread_done_q;
    assign bus.busy        = busy_q;
    assign bus.blk_count   = blk_count_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_blk_sched.sv
// tb/tb_blk_sched.sv - scoreboard bench for blk_sched grants, completions and errors
module tb_blk_sched;
    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    int          exp_num[$];
    bit          exp_nc[$];
    logic [5:0]  exp_done[$];

    blk_sched_if #(.N_THREADS(6)) bus ();

    blk_sched #(.N_THREADS(6), .BLK_TIMEOUT(127)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_grant(input int n, input bit nc);
        exp_num.push_back(n);
        exp_nc.push_back(nc);
    endtask

    // Monitor: every start and every done pulse must match the next queued expectation.
    int         mon_n;
    bit         mon_c;
    logic [5:0] mon_d;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.blk_start) begin
                if (exp_num.size() == 0) begin
                    check("unexpected_start", 32'(bus.thread_num), 32'hFFFF_FFFF);
                end else begin
                    mon_n = exp_num.pop_front();
                    mon_c = exp_nc.pop_front();
                    check("thread_num", 32'(bus.thread_num), mon_n);
                    check("new_comp", 32'(bus.new_comp), 32'(mon_c));
                    check("thread_ack", 32'(bus.thread_ack), 32'(1) << mon_n);
                end
            end else if (bus.thread_ack != 0) begin
                check("stray_ack", 32'(bus.thread_ack), 0);
            end
            if (bus.thread_done != 0) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 32'(bus.thread_done), 0);
                end else begin
                    mon_d = exp_done.pop_front();
                    check("thread_done", 32'(bus.thread_done), 32'(mon_d));
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Wait for the next start, apply next_req, then return blk_end end_delay cycles later.
    task automatic do_block(input int end_delay, input bit ec, input logic [5:0] next_req,
                            output int s_cyc);
        int k;
        @(negedge clk);
        k = 0;
        while (!bus.blk_start && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!bus.blk_start) begin
            check("start_wait_expired", 0, 1);
            s_cyc = -1;
            return;
        end
        s_cyc = cyc;
        bus.thread_req = next_req;
        check("busy_at_start", 32'(bus.busy), 1);
        if (end_delay > 0) begin
            repeat (end_delay) @(posedge clk);
            #1;
            bus.blk_end  = 1'b1;
            bus.end_comp = ec;
            @(posedge clk);
            #1;
            bus.blk_end  = 1'b0;
            bus.end_comp = 1'b0;
        end
    endtask

    int         s;
    int         rel;
    int         starts[7];
    logic [5:0] pat;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.thread_req      = '0;
        bus.thread_new_comp = '0;
        bus.core_rdy        = 1'b0;
        bus.blk_end         = 1'b0;
        bus.end_comp        = 1'b0;

        @(negedge clk);
        check("rst_blk_start", 32'(bus.blk_start), 0);
        check("rst_thread_num", 32'(bus.thread_num), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_blk_count", 32'(bus.blk_count), 0);

        // Single thread, completion after 10 cycles.
        bus.thread_req      = 6'b000001;
        bus.thread_new_comp = 6'b000001;
        bus.core_rdy        = 1'b1;
        push_grant(0, 1'b1);
        exp_done.push_back(6'b000001);
        @(posedge clk);
        #1 rst = 1'b0;
        rel = cyc;
        do_block(10, 1'b1, 6'b000000, s);
        check("t1_start_latency", s, rel + 1);
        @(negedge clk);
        check("t1_blk_count", 32'(bus.blk_count), 1);
        check("t1_busy_after", 32'(bus.busy), 0);

        // All threads requesting: full rotation with wrap back to 0.
        do_reset();
        pat = 6'b010110;
        bus.thread_new_comp = pat;
        bus.thread_req      = 6'b111111;
        for (int i = 0; i < 7; i++) begin
            push_grant(i % 6, pat[i % 6]);
            exp_done.push_back(6'(1 << (i % 6)));
        end
        for (int i = 0; i < 7; i++) begin
            do_block(5, 1'b1, (i == 6) ? 6'b000000 : 6'b111111, starts[i]);
        end
        for (int i = 1; i < 7; i++) begin
            check("t2_start_spacing", starts[i] - starts[i-1], 7);
        end
        @(negedge clk);
        check("t2_blk_count", 32'(bus.blk_count), 7);

        // Sparse requesters: skip idle threads across the wrap, no end_comp.
        do_reset();
        bus.thread_new_comp = 6'b000000;
        bus.thread_req      = 6'b100100;
        push_grant(2, 1'b0);
        push_grant(5, 1'b0);
        push_grant(2, 1'b0);
        do_block(4, 1'b0, 6'b100100, s);
        do_block(4, 1'b0, 6'b100100, s);
        do_block(4, 1'b0, 6'b000000, s);
        @(negedge clk);
        check("t3_last_num", 32'(bus.thread_num), 2);
        check("t3_blk_count", 32'(bus.blk_count), 3);

        // Core not ready holds off the grant.
        do_reset();
        bus.core_rdy        = 1'b0;
        bus.thread_req      = 6'b001000;
        bus.thread_new_comp = 6'b001000;
        repeat (20) @(posedge clk);
        check("t4_idle_busy", 32'(bus.busy), 0);
        push_grant(3, 1'b1);
        exp_done.push_back(6'b001000);
        @(posedge clk);
        #1 bus.core_rdy = 1'b1;
        rel = cyc;
        do_block(6, 1'b1, 6'b000000, s);
        check("t4_start_latency", s, rel + 1);

        // Timeout: err exactly 128 cycles after the start, then no further starts.
        do_reset();
        bus.thread_new_comp = 6'b000000;
        bus.thread_req      = 6'b000001;
        push_grant(0, 1'b0);
        do_block(-1, 1'b0, 6'b000001, s);
        repeat (127) @(negedge clk);
        check("t5_err_before", 32'(bus.err), 0);
        @(negedge clk);
        check("t5_err_at_128", 32'(bus.err), 1);
        repeat (20) @(negedge clk);
        check("t5_err_sticky", 32'(bus.err), 1);
        check("t5_busy_err", 32'(bus.busy), 0);
        check("t5_count_err", 32'(bus.blk_count), 0);
        push_grant(0, 1'b0);
        exp_done.push_back(6'b000001);
        do_reset();
        rel = cyc;
        check("t5_err_cleared", 32'(bus.err), 0);
        do_block(3, 1'b1, 6'b000000, s);
        check("t5_restart_latency", s, rel + 1);

        // Protocol error in IDLE; stray end_comp alone is harmless.
        do_reset();
        @(posedge clk);
        #1 bus.end_comp = 1'b1;
        @(posedge clk);
        #1 bus.end_comp = 1'b0;
        @(negedge clk);
        check("t6_end_comp_alone", 32'(bus.err), 0);
        @(posedge clk);
        #1 bus.blk_end = 1'b1;
        @(posedge clk);
        #1 bus.blk_end = 1'b0;
        @(negedge clk);
        check("t6_blk_end_idle", 32'(bus.err), 1);

        // Reset during WAIT abandons the block without a done pulse.
        do_reset();
        bus.thread_req = 6'b000100;
        push_grant(2, 1'b0);
        exp_done.push_back(6'b000100);
        push_grant(2, 1'b0);
        do_block(3, 1'b1, 6'b000100, s);
        do_block(-1, 1'b0, 6'b000000, s);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("t7_rst_busy", 32'(bus.busy), 0);
        check("t7_rst_thread_num", 32'(bus.thread_num), 0);
        check("t7_rst_blk_count", 32'(bus.blk_count), 0);
        check("t7_rst_done", 32'(bus.thread_done), 0);
        check("t7_rst_err", 32'(bus.err), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        bus.blk_end  = 1'b1;
        bus.end_comp = 1'b1;
        bus.blk_end  = 1'b0;
        bus.end_comp = 1'b0;
        repeat (10) @(negedge clk);

        check("sb_grants_left", exp_num.size(), 0);
        check("sb_done_left", exp_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
